md_unit: RTL and testbench

Multiply/divide responder serving the E-stage's mult/div requests. It accepts one operation per request and holds its own HI/LO registers. Until the result is committed it raises busy, which the E-stage turns into its stall output to the hazard controller. It completes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and MTHI/MTLO in a single cycle.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_arith.sv | 70 +++++++
 rtl/md_unit.sv | 113 +++++++++++
 tb/tb_md_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Also used by the D-stage decoder and the E-stage stall logic.
//   MD_W     : datapath width
//   MD_OP_W  : width of the md_op operation code
//   md_op_e  : operation encoding
//   md_state_e : md_unit sequencing states
package md_pkg;

    localparam int MD_W    = 32;
    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   md_op    in  operation code (md_op_e encoding)
//   a, b     in  operands (rs, rt)
//   res_hi   out result destined for HI (product high / remainder)
//   res_lo   out result destined for LO (product low / quotient)
//   div_zero out DIV/DIVU with b == 0; result must be discarded
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [MD_W-1:0]    a,
    input  logic [MD_W-1:0]    b,
    output logic [MD_W-1:0]    res_hi,
    output logic [MD_W-1:0]    res_lo,
    output logic               div_zero
);

    logic signed [2*MD_W-1:0] prod_s;
    logic        [2*MD_W-1:0] prod_u;
    logic signed [MD_W-1:0]   quot_s;
    logic signed [MD_W-1:0]   rem_s;
    logic        [MD_W-1:0]   quot_u;
    logic        [MD_W-1:0]   rem_u;
    logic        [MD_W-1:0]   div_b;
    logic                     b_zero;
    logic                     div_ovf;

    assign b_zero  = (b == '0);
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 in the overflow case gives exactly the
    // wanted quotient (0x80000000) and remainder (0) without overflowing.
    // A zero divisor is also replaced so the divider never sees 0.
    assign div_b = (b_zero || div_ovf) ? 32'd1 : b;

    always_comb begin
        prod_s   = $signed({{MD_W{a[MD_W-1]}}, a}) * $signed({{MD_W{b[MD_W-1]}}, b});
        prod_u   = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};
        quot_s   = $signed(a) / $signed(div_b);
        rem_s    = $signed(a) % $signed(div_b);
        quot_u   = a / div_b;
        rem_u    = a % div_b;
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[2*MD_W-1:MD_W];
                res_lo = prod_s[MD_W-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*MD_W-1:MD_W];
                res_lo = prod_u[MD_W-1:0];
            end
            MD_DIV: begin
                res_hi   = rem_s;
                res_lo   = quot_s;
                div_zero = b_zero;
            end
            MD_DIVU: begin
                res_hi   = rem_u;
                res_lo   = quot_u;
                div_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide responder with architectural HI/LO registers.
// Multi-cycle ops hold busy for a fixed latency, then commit HI/LO;
// MTHI/MTLO write in one cycle. Requests while busy are ignored.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   start  in  request strobe
//   md_op  in  operation code (md_op_e encoding)
//   a, b   in  operands, captured at the accepting edge
//   busy   out operation in flight
//   hi, lo out architectural HI/LO
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no op in flight; accepts start, busy=0
// ST_RUN  | counting down latency; commits pending at 0
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [MD_W-1:0]    a,
    input  logic [MD_W-1:0]    b,
    output logic               busy,
    output logic [MD_W-1:0]    hi,
    output logic [MD_W-1:0]    lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    md_state_e        state;
    logic [CNT_W-1:0] counter;
    logic [MD_W-1:0]  pend_hi;
    logic [MD_W-1:0]  pend_lo;
    logic             pend_drop;

    logic [MD_W-1:0]  res_hi;
    logic [MD_W-1:0]  res_lo;
    logic             div_zero;

    md_arith u_arith (
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_drop <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                pend_hi   <= res_hi;
                                pend_lo   <= res_lo;
                                pend_drop <= 1'b0;
                                counter   <= CNT_W'(MULT_CYCLES - 1);
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                pend_hi   <= res_hi;
                                pend_lo   <= res_lo;
                                pend_drop <= div_zero;
                                counter   <= CNT_W'(DIV_CYCLES - 1);
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (counter == '0) begin
                        if (!pend_drop) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request, scrambles operands after acceptance, and waits for
    // the unit to go idle, checking that HI/LO hold while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int cyc);
        logic [31:0] old_hi, old_lo;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        a     = $urandom;
        b     = $urandom;
        cyc   = 0;
        while (busy && cyc < 100) begin
            cyc++;
            check("hold_hi", hi, old_hi);
            check("hold_lo", lo, old_lo);
            tick();
        end
    endtask

    function automatic int model_lat(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    function automatic void model(input logic [2:0] op, input logic [31:0] va,
                                  input logic [31:0] vb, inout logic [31:0] h,
                                  inout logic [31:0] l);
        longint          sa, sb, p, q, r;
        longint unsigned pu;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        case (op)
            3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd2: begin
                pu = longint'({32'b0, va}) * longint'({32'b0, vb});
                h = pu[63:32];
                l = pu[31:0];
            end
            3'd3: if (vb != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            3'd4: if (vb != 0) begin l = va / vb; h = va % vb; end
            3'd5: h = va;
            3'd6: l = va;
            default: ;
        endcase
    endfunction

    initial begin
        int          cyc;
        logic [31:0] m_hi, m_lo;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vecs.push_back('{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10});
        vecs.push_back('{3'd4, 32'd5, 32'd0, 32'h11, 32'h22, 10});
        vecs.push_back('{3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10});
        vecs.push_back('{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5});
        vecs.push_back('{3'd5, 32'hDEAD, 32'd9, 32'hDEAD, 32'h22, 0});
        vecs.push_back('{3'd6, 32'hBEEF, 32'd9, 32'h11, 32'hBEEF, 0});
        vecs.push_back('{3'd0, 32'd1, 32'd1, 32'h11, 32'h22, 0});
        vecs.push_back('{3'd7, 32'd1, 32'd1, 32'h11, 32'h22, 0});

        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd5;
        a     = 32'h5;
        b     = 32'h0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        tick();

        // table-driven vectors, each from a known HI/LO preset
        foreach (vecs[i]) begin
            do_op(3'd5, 32'h11, 32'h0, cyc);
            do_op(3'd6, 32'h22, 32'h0, cyc);
            do_op(vecs[i].op, vecs[i].va, vecs[i].vb, cyc);
            check($sformatf("vec%0d_cyc", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_idle", i), {31'b0, busy}, 32'd0);
        end

        // MTLO during MULT busy is ignored
        start = 1'b1; md_op = 3'd1; a = 32'd3; b = 32'd5;
        tick();
        md_op = 3'd6; a = 32'hABCD;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; tick(); end
        start = 1'b0;
        check("ign_cyc", cyc, 5);
        check("ign_lo", lo, 32'd15);
        check("ign_hi", hi, 32'd0);
        // MTLO in the first idle cycle after busy falls
        do_op(3'd6, 32'hABCD, 32'h0, cyc);
        check("b2b_cyc", cyc, 0);
        check("b2b_lo", lo, 32'hABCD);

        // reset during the fourth busy cycle of a DIV
        start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; md_op = 3'd0;
        check("mid_busy", {31'b0, busy}, 32'd1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        do_op(3'd1, 32'd3, 32'd4, cyc);
        check("post_rst_cyc", cyc, 5);
        check("post_rst_lo", lo, 32'd12);
        check("post_rst_hi", hi, 32'd0);

        // randomized ops against the reference model
        do_op(3'd5, 32'h0, 32'h0, cyc);
        do_op(3'd6, 32'h0, 32'h0, cyc);
        m_hi = 32'h0;
        m_lo = 32'h0;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = ra >> $urandom_range(0, 31); rb = rb >> $urandom_range(16, 31); end
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(rop, ra, rb, m_hi, m_lo);
            do_op(rop, ra, rb, cyc);
            check($sformatf("rnd%0d_op%0d_cyc", i, rop), cyc, model_lat(rop));
            check($sformatf("rnd%0d_op%0d_hi", i, rop), hi, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, rop), lo, m_lo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
